// File: rtl/fir_decim_fifo.sv
// Decimates the FIR output stream by DECIM and buffers kept samples in a
// first-word-fall-through FIFO with a sticky overflow flag for dropped samples.
module fir_decim_fifo #(
    parameter int WIDTH = 8,
    parameter int DECIM = 4,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

    logic [PW-1:0]    phase_q, phase_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem [DEPTH];

    logic kept;
    logic pop;
    logic push;
    logic drop;

    // Handshake: a word transfers on any cycle where out_valid && out_ready;
    // out_valid never waits on out_ready, and out_data holds until transferred.
    always_comb begin
        kept = din_valid && (phase_q == '0);
        pop  = (count_q != '0) && out_ready;
        // A full FIFO still accepts a kept sample when the head leaves this cycle.
        push = kept && ((count_q != (AW+1)'(DEPTH)) || pop);
        drop = kept && !push;

        phase_d = phase_q;
        if (din_valid) begin
            phase_d = (phase_q == PW'(DECIM - 1)) ? '0 : phase_q + PW'(1);
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set.
        overflow_d = drop | (overflow_q & ~clr_ovf);
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            phase_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset && push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
- Downstream stage of the 8-bit four-tap moving-average FIR filter.
- Takes the filter output stream, decimates it by DECIM, and buffers the kept samples in a small first-word-fall-through FIFO.
- A consumer drains the FIFO through a valid/ready handshake.
- Drops caused by backpressure are recorded in a sticky overflow flag.

Parameters:
- WIDTH, 8: sample width; matches FIR Dout.
- DECIM, 4: decimation ratio, legal range 1..16; keep one of every DECIM valid input samples.
- DEPTH, 8: FIFO entries; power of 2, 2..64. Pointer width AW = log2(DEPTH), derived locally.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; reset==0 at a rising CLK edge initialises the block.
- din  in  WIDTH  filter output sample.
- din_valid  in  1  din carries a new sample this cycle.
- out_data  out  WIDTH  head-of-FIFO sample.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data this cycle.
- count  out  AW+1  entries currently stored, 0..DEPTH.
- overflow  out  1  sticky; a kept sample was dropped because the FIFO was full.
- clr_ovf  in  1  clears overflow.

Behaviour:
Reset (reset==0 at edge):
- phase=0, read/write pointers=0, count=0, overflow=0.
- Hence out_valid=0 and out_data=0.
- Any stored contents are discarded, including mid-stream. The memory array itself is not cleared.

Decimation:
- phase counts 0..DECIM-1 and advances only on cycles with din_valid=1; it wraps from DECIM-1 to 0.
- A sample is "kept" when din_valid=1 and phase==0, so the first valid sample after reset is always kept.
- DECIM=1 keeps every valid sample.
- phase advances whether the kept sample is stored or dropped.

Push/pop:
- pop = out_valid & out_ready.
- push = kept & (count<DEPTH | pop). A full FIFO accepts a kept sample when a pop occurs in the same cycle.
- Kept sample with count==DEPTH and no pop: sample dropped, overflow set to 1, FIFO unchanged.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Empty FIFO: no pop is possible (out_valid=0), so a kept sample is simply written.
- Pointers wrap modulo DEPTH. count is held separately, which distinguishes full from empty.

Output:
- FWFT: out_data = mem[rd_ptr] when count!=0, forced to 0 when count==0.
- out_valid = (count!=0).
- Latency: a sample kept at edge t into an empty FIFO is presented on out_data/out_valid in the cycle after edge t. That is one cycle din->out.
- out_data stays stable while out_valid=1 and out_ready=0.
- out_ready while empty is ignored.

Overflow:
- Set on a drop and held until clr_ovf=1.
- If clr_ovf=1 and a drop occur in the same cycle, overflow is 1 (set wins).
- Reset clears it.

Arithmetic:
- No sample arithmetic; data is stored verbatim, WIDTH bits.
- count is updated as +1 on push only, -1 on pop only, unchanged otherwise.

Test Plan:
1. Decimated flow-through.
   - Stimulus: DECIM=4, DEPTH=8. Release reset. din_valid=1 continuously with din=1,2,...,16; out_ready=1.
   - Required: out_data sequence 1,5,9,13. Each value appears one cycle after it is driven. count never exceeds 1. overflow=0.
2. Fill and overflow.
   - Stimulus: out_ready=0; 36 valid samples din=1..36.
   - Required: 9 samples kept. 1,5,...,29 stored, count=8. Sample 33 dropped, overflow=1.
   - Then out_ready=1: drains 1,5,9,13,17,21,25,29 in order, count reaches 0, out_valid=0, out_data=0.
3. Full with simultaneous pop.
   - Stimulus: count=8; a kept sample arrives (din=0xAA) in the same cycle out_ready=1.
   - Required: count stays 8, overflow stays 0, 0xAA is the last entry drained.
4. Gapped input.
   - Stimulus: DECIM=3; din_valid pattern 1,0,0,1,1,0,1,1 with din=10,11,...,17.
   - Required: kept samples are 10 and 16 only (phase ignores invalid cycles).
5. Overflow clear priority.
   - Stimulus: clr_ovf=1 in the same cycle as a drop.
   - Required: overflow=1 afterwards. clr_ovf=1 with no drop the following cycle gives overflow=0.
6. Mid-stream reset.
   - Stimulus: count=5, out_ready=0; reset=0 for one edge.
   - Required: next cycle count=0, out_valid=0, out_data=0, overflow=0. The first valid sample after release (din=0x42) is kept and output one cycle later.
